// File: rtl/pic_core_n_if.sv
// pic_core_n_if: CPU bus strobes, IRQ lines and INTA/vector
// path of the N-line programmable interrupt controller core.
interface pic_core_n_if #(
  parameter int NUM_IRQ = 8
);
  logic               cs;
  logic               wr;
  logic               rd;
  logic               a0;
  logic [7:0]         din;
  logic [7:0]         dout;
  logic               dout_vld;
  logic [NUM_IRQ-1:0] irq;
  logic               inta;
  logic               int_o;
  logic               ready;

  modport master (
    output cs, wr, rd, a0, din, irq, inta,
    input  dout, dout_vld, int_o, ready
  );

  modport slave (
    input  cs, wr, rd, a0, din, irq, inta,
    output dout, dout_vld, int_o, ready
  );
endinterface

// File: rtl/pic_core_n.sv
// pic_core_n: N-line 8259-style interrupt controller core.
// Optional poll command is built when PIC_POLL_EN is defined.
module pic_core_n #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LW          = 3
) (
  input logic         clk,
  input logic         reset,
  pic_core_n_if.slave bus
);

  localparam int W = 1 << LW;
  localparam logic [W-1:0] VMASK =
    {W{1'b1}} >> (W - NUM_IRQ);
  localparam logic [LW:0] NL  = NUM_IRQ[LW:0];
  localparam logic [LW:0] ONE = {{LW{1'b0}}, 1'b1};
  localparam logic [LW-1:0] LAST = NL[LW-1:0] - 1'b1;

  typedef enum logic [1:0] {
    S_UNINIT,
    S_WAIT2,
    S_WAIT4,
    S_READY
  } state_e;

  typedef struct packed {
    logic          f;
    logic [LW-1:0] rk;
    logic [LW-1:0] lv;
  } pick_t;

  // Best-rank set bit of v when lp is the lowest-priority level.
  function automatic pick_t pick(
    input logic [W-1:0]  v,
    input logic [LW-1:0] lp
  );
    pick_t       r;
    logic [LW:0] s;
    r = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      s = {1'b0, lp} + ONE + k[LW:0];
      if (s >= NL) s = s - NL;
      if (v[s[LW-1:0]])
        r = '{f: 1'b1, rk: k[LW-1:0], lv: s[LW-1:0]};
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  logic          ltim_q, ltim_d;
  logic          ic4_q, ic4_d;
  logic          aeoi_q, aeoi_d;
  logic [4:0]    base_q, base_d;
  logic [W-1:0]  imr_q, imr_d;
  logic [W-1:0]  isr_q, isr_d;
  logic [W-1:0]  irr_q, irr_d;
  logic [LW-1:0] lp_q, lp_d;
  logic          ris_q, ris_d;
  logic          arot_q, arot_d;
  logic          phase_q, phase_d;
  logic [LW-1:0] win_q, win_d;
  logic          spur_q, spur_d;
  logic [7:0]    dout_q, dout_d;
  logic          dvld_q, dvld_d;
  logic          int_q, int_d;
  logic [W-1:0]  prev_q;
`ifdef PIC_POLL_EN
  logic          poll_q, poll_d;
`endif

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]  irq_pad;
  logic [W-1:0]  s_now;
  logic [W-1:0]  pend;
  pick_t         pw;
  pick_t         iw;
  logic          rdy;
  logic          wr_en;
  logic          rd_en;
  logic          icw1;
  logic          inta1;
  logic          inta2;
  logic          ocw2;
  logic          ocw3;
  logic [LW-1:0] lvl;
  logic          l_ok;
  logic          poll_arm;
  logic [7:0]    din;

  always_comb begin
    irq_pad = '0;
    irq_pad[NUM_IRQ-1:0] = bus.irq;
  end

  assign s_now = sync_q[SYNC_STAGES-1];
  assign din   = bus.din;

  always_comb begin
    state_d = state_q;
    ltim_d  = ltim_q;
    ic4_d   = ic4_q;
    aeoi_d  = aeoi_q;
    base_d  = base_q;
    imr_d   = imr_q;
    isr_d   = isr_q;
    irr_d   = irr_q;
    lp_d    = lp_q;
    ris_d   = ris_q;
    arot_d  = arot_q;
    phase_d = phase_q;
    win_d   = win_q;
    spur_d  = spur_q;
    dout_d  = dout_q;
    dvld_d  = 1'b0;
`ifdef PIC_POLL_EN
    poll_d   = poll_q;
    poll_arm = poll_q;
`else
    poll_arm = 1'b0;
`endif

    rdy   = state_q == S_READY;
    wr_en = bus.cs & bus.wr;
    rd_en = bus.cs & bus.rd;
    icw1  = wr_en & ~bus.a0 & din[4];
    inta1 = bus.inta & rdy & ~icw1 & ~phase_q;
    inta2 = bus.inta & rdy & ~icw1 & phase_q;
    ocw2  = wr_en & rdy & ~bus.a0
          & (din[4:3] == 2'b00);
    ocw3  = wr_en & rdy & ~bus.a0
          & (din[4:3] == 2'b01);
    lvl   = din[LW-1:0];
    l_ok  = {1'b0, lvl} < NL;

    pend = irr_q & ~imr_q & VMASK;
    pw   = pick(pend, lp_q);
    iw   = pick(isr_q, lp_q);

    int_d = rdy & ~icw1 & ~poll_arm & pw.f
          & (~iw.f | (pw.rk < iw.rk));

    if (icw1) begin
      ltim_d  = din[3];
      ic4_d   = din[0];
      aeoi_d  = 1'b0;
      imr_d   = '0;
      isr_d   = '0;
      irr_d   = '0;
      arot_d  = 1'b0;
      lp_d    = LAST;
      phase_d = 1'b0;
      state_d = S_WAIT2;
`ifdef PIC_POLL_EN
      poll_d  = 1'b0;
`endif
    end else begin
      if (rdy) begin
        if (ltim_q) irr_d = s_now;
        else irr_d = (irr_q | (s_now & ~prev_q)) & s_now;
      end

      if (wr_en && bus.a0) begin
        unique case (state_q)
          S_WAIT2: begin
            base_d  = din[7:3];
            state_d = ic4_q ? S_WAIT4 : S_READY;
          end
          S_WAIT4: begin
            aeoi_d  = din[1];
            state_d = S_READY;
          end
          S_READY: imr_d = din & VMASK;
          default: ;
        endcase
      end

      // EOI works on the pre-cycle ISR; INTA1 set below wins.
      if (ocw2 && l_ok) begin
        unique case (din[7:5])
          3'b001: if (iw.f) isr_d[iw.lv] = 1'b0;
          3'b011: isr_d[lvl] = 1'b0;
          3'b101: if (iw.f) begin
            isr_d[iw.lv] = 1'b0;
            lp_d = iw.lv;
          end
          3'b111: begin
            isr_d[lvl] = 1'b0;
            lp_d = lvl;
          end
          3'b110: lp_d = lvl;
          3'b100: arot_d = 1'b1;
          3'b000: arot_d = 1'b0;
          default: ;
        endcase
      end

      if (ocw3 && din[1]) ris_d = din[0];
`ifdef PIC_POLL_EN
      if (ocw3 && din[2]) poll_d = 1'b1;
`endif

      if (inta1) begin
        phase_d = 1'b1;
        spur_d  = ~pw.f;
        win_d   = pw.f ? pw.lv : LAST;
        if (pw.f) begin
          isr_d[pw.lv] = 1'b1;
          if (!ltim_q) irr_d[pw.lv] = 1'b0;
        end
      end

      if (inta2) begin
        phase_d = 1'b0;
        dout_d  = {base_q, win_q};
        dvld_d  = 1'b1;
        if (aeoi_q && !spur_q) begin
          isr_d[win_q] = 1'b0;
          if (arot_q) lp_d = win_q;
        end
      end else if (rd_en) begin
        dvld_d = 1'b1;
        if (bus.a0) dout_d = imr_q;
        else if (ris_q) dout_d = isr_q;
        else dout_d = irr_q;
`ifdef PIC_POLL_EN
        if (poll_q && !bus.a0) begin
          poll_d = 1'b0;
          dout_d = pw.f ? {1'b1, 4'b0, pw.lv} : 8'h00;
          if (pw.f) begin
            isr_d[pw.lv] = 1'b1;
            if (!ltim_q) irr_d[pw.lv] = 1'b0;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_UNINIT;
      ltim_q  <= 1'b0;
      ic4_q   <= 1'b0;
      aeoi_q  <= 1'b0;
      base_q  <= '0;
      imr_q   <= '0;
      isr_q   <= '0;
      irr_q   <= '0;
      lp_q    <= LAST;
      ris_q   <= 1'b0;
      arot_q  <= 1'b0;
      phase_q <= 1'b0;
      win_q   <= '0;
      spur_q  <= 1'b0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      int_q   <= 1'b0;
      prev_q  <= '0;
      sync_q  <= '0;
`ifdef PIC_POLL_EN
      poll_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ltim_q  <= ltim_d;
      ic4_q   <= ic4_d;
      aeoi_q  <= aeoi_d;
      base_q  <= base_d;
      imr_q   <= imr_d;
      isr_q   <= isr_d;
      irr_q   <= irr_d;
      lp_q    <= lp_d;
      ris_q   <= ris_d;
      arot_q  <= arot_d;
      phase_q <= phase_d;
      win_q   <= win_d;
      spur_q  <= spur_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      int_q   <= int_d;
      prev_q  <= s_now;
      sync_q[0] <= irq_pad;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
`ifdef PIC_POLL_EN
      poll_q  <= poll_d;
`endif
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dvld_q;
  assign bus.int_o    = int_q;
  assign bus.ready    = state_q == S_READY;

endmodule

// File: tb/tb_pic_core_n.sv
// tb_pic_core_n: scoreboard bench for pic_core_n with six
// request lines; dout_vld pulses are matched against a queue.
module tb_pic_core_n;
  localparam int N  = 6;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  pic_core_n_if #(.NUM_IRQ(N)) bus ();

  pic_core_n #(
    .NUM_IRQ(N),
    .SYNC_STAGES(SS),
    .LW(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h want %02h",
               tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    bus.cs = 1'b1; bus.wr = 1'b1;
    bus.a0 = a; bus.din = d;
    tick();
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic rd(
    input logic a, input logic [7:0] e, input string t
  );
    exp_q.push_back(e); tag_q.push_back(t);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.a0 = a;
    tick();
    bus.cs = 1'b0; bus.rd = 1'b0;
    tick();
  endtask

  task automatic ack(input logic [7:0] e, input string t);
    bus.inta = 1'b1; tick();
    bus.inta = 1'b0; tick();
    exp_q.push_back(e); tag_q.push_back(t);
    bus.inta = 1'b1; tick();
    bus.inta = 1'b0; tick();
  endtask

  task automatic wait_int(input string t, input int n);
    int i = 0;
    while (!bus.int_o && i < n) begin
      tick();
      i++;
    end
    check(t, {7'b0, bus.int_o}, 8'h01);
  endtask

  task automatic idle_int0(input string t);
    repeat (6) tick();
    check(t, {7'b0, bus.int_o}, 8'h00);
  endtask

  always @(negedge clk) begin
    if (bus.dout_vld) begin
      if (exp_q.size() == 0)
        check("extra_vld", {7'b0, bus.dout_vld}, 8'h00);
      else
        check(tag_q.pop_front(), bus.dout, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
    bus.a0 = 1'b0; bus.din = '0; bus.inta = 1'b0;
    bus.irq = '0;
    tick(); tick();
    check("rst_ready", {7'b0, bus.ready}, 8'h00);
    check("rst_int", {7'b0, bus.int_o}, 8'h00);
    check("rst_vld", {7'b0, bus.dout_vld}, 8'h00);
    check("rst_dout", bus.dout, 8'h00);
    reset = 1'b0;
    tick();

    wr(1'b0, 8'h13);
    check("rdy_w2", {7'b0, bus.ready}, 8'h00);
    wr(1'b1, 8'h40);
    check("rdy_w4", {7'b0, bus.ready}, 8'h00);
    wr(1'b1, 8'h00);
    check("rdy_init", {7'b0, bus.ready}, 8'h01);
    rd(1'b1, 8'h00, "imr_init");

    wr(1'b0, 8'h0B);
    bus.irq[3] = 1'b1;
    wait_int("int_irq3", SS + 2);
    ack(8'h43, "vec3");
    rd(1'b0, 8'h08, "isr3");
    wr(1'b0, 8'h20);
    rd(1'b0, 8'h00, "isr_eoi");
    idle_int0("int_after_eoi");

    bus.irq[3] = 1'b0;
    repeat (3) tick();
    bus.irq[3] = 1'b1;
    wait_int("int_irq3b", SS + 2);
    ack(8'h43, "vec3b");
    bus.irq[5] = 1'b1;
    idle_int0("nest_low5");
    bus.irq[1] = 1'b1;
    wait_int("int_irq1", SS + 2);
    ack(8'h41, "vec1");
    rd(1'b0, 8'h0A, "isr_nest");
    wr(1'b0, 8'h20);
    rd(1'b0, 8'h08, "isr_ns1");
    idle_int0("nest_hold5");
    wr(1'b0, 8'h20);
    wait_int("int_irq5", SS + 2);
    ack(8'h45, "vec5");
    wr(1'b0, 8'h20);
    rd(1'b0, 8'h00, "isr_clear");
    bus.irq = '0;
    repeat (4) tick();

    wr(1'b0, 8'hC2);
    bus.irq[1] = 1'b1;
    bus.irq[4] = 1'b1;
    wait_int("int_rot", SS + 2);
    wr(1'b0, 8'h0A);
    rd(1'b0, 8'h12, "irr_rot");
    wr(1'b0, 8'h0B);
    ack(8'h44, "vec_rot");
    bus.irq[2] = 1'b1;
    repeat (4) tick();
    wr(1'b0, 8'hC7);
    wr(1'b0, 8'h64);
    wait_int("int_rot2", SS + 2);
    ack(8'h41, "vec_l7_ign");
    wr(1'b0, 8'h20);
    bus.irq = '0;
    repeat (4) tick();

    wr(1'b0, 8'h13);
    wr(1'b1, 8'h40);
    wr(1'b1, 8'h02);
    wr(1'b0, 8'h80);
    wr(1'b0, 8'h0B);
    bus.irq[2] = 1'b1;
    wait_int("int_aeoi", SS + 2);
    ack(8'h42, "vec_aeoi");
    rd(1'b0, 8'h00, "isr_aeoi");
    bus.irq[2] = 1'b0;
    repeat (3) tick();
    bus.irq[0] = 1'b1;
    bus.irq[3] = 1'b1;
    wait_int("int_lp2", SS + 2);
    ack(8'h43, "vec_lp2");
    rd(1'b0, 8'h00, "isr_lp2");
    bus.irq = '0;
    repeat (4) tick();
    ack(8'h45, "vec_spur");
    rd(1'b0, 8'h00, "isr_spur");

    wr(1'b1, 8'h01);
    rd(1'b1, 8'h01, "imr_set");
    bus.irq[2] = 1'b1;
    wait_int("int_pre_rst", SS + 2);
    bus.inta = 1'b1; tick();
    bus.inta = 1'b0; tick();
    reset = 1'b1; tick();
    check("mid_rdy", {7'b0, bus.ready}, 8'h00);
    reset = 1'b0;
    bus.inta = 1'b1; tick();
    bus.inta = 1'b0;
    repeat (3) tick();
    check("post_vld", {7'b0, bus.dout_vld}, 8'h00);
    check("post_rdy", {7'b0, bus.ready}, 8'h00);
    check("post_int", {7'b0, bus.int_o}, 8'h00);
    rd(1'b1, 8'h00, "imr_rst");
    bus.irq = '0;
    repeat (3) tick();

    check("sb_left", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pic_core_n.md
Name: pic_core_n

Overview:
- Parametrised, fully synchronous programmable interrupt controller core with N request lines. Successor to the 8-line 8259-style control core.
- Holds IRR, ISR and IMR, and runs an ICW1/ICW2/(ICW4) init FSM.
- Implements fully-nested priority with mod-N rotation and specific priority set, specific/non-specific EOI and auto-EOI.
- Runs a two-pulse INTA vector handshake.
- Sits between the CPU bus adapter (cs/rd/wr/a0 strobes already synchronised to clk) and the peripheral IRQ lines.

Parameters:
- NUM_IRQ, 8, number of request lines; legal range 2..8.
- SYNC_STAGES, 2, synchroniser flops on each irq input; legal range 1..3.
- LW, 3, width of the level-index field; fixed at 3.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cs  in  1  chip select, active-high, qualifies rd/wr
- wr  in  1  one-cycle write strobe
- rd  in  1  one-cycle read strobe
- a0  in  1  register select
- din  in  8  write data
- dout  out  8  read/vector data, registered
- dout_vld  out  1  one-cycle pulse, dout valid
- irq  in  NUM_IRQ  async interrupt requests, active-high
- inta  in  1  one-cycle interrupt-acknowledge pulse
- int_o  out  1  interrupt request to CPU, registered
- ready  out  1  init sequence complete

Behaviour:
- Reset: all of the following are 0: dout, dout_vld, int_o, ready, IRR, ISR, IMR, ICW regs, OCW3 select, AEOI-rotate flag, inta phase. lp (lowest-priority level) = NUM_IRQ-1. FSM = UNINIT.
- Writes, decoded only when cs&wr:
  - a0=0 & din[4]=1 → ICW1 in any state. Captures LTIM=din[3] and IC4=din[0]. Clears IMR, ISR, IRR-edge latches and the AEOI-rotate flag. Sets lp=NUM_IRQ-1, ready=0, inta phase=0, FSM → WAIT2.
  - WAIT2, a0=1: ICW2 base=din[7:3]. Next state is WAIT4 if IC4=1, else READY.
  - WAIT4, a0=1: AEOI=din[1]; FSM → READY.
  - READY, a0=1: OCW1, IMR=din[NUM_IRQ-1:0].
  - READY, a0=0, din[4:3]=00: OCW2 command with code din[7:5] and level L=din[2:0]:
    - 001: non-specific EOI, clears the highest-priority ISR bit.
    - 011: specific EOI, clears ISR[L].
    - 101: rotate on non-specific EOI, clears that bit and sets lp to its level.
    - 111: rotate on specific EOI, clears ISR[L] and sets lp=L.
    - 110: set priority, lp=L.
    - 100 / 000: set / clear the AEOI-rotate flag.
    - 010: no-op.
    - Any L ≥ NUM_IRQ: command ignored.
  - READY, a0=0, din[4:3]=01: OCW3. If din[1]=1, the read select becomes RIS=din[0].
  - WAIT2/WAIT4 with a0=0 & din[4]=0: ignored.
  - UNINIT with a0=1: ignored.
- ready=1 only in READY.
- Priority: level (lp+1+k) mod NUM_IRQ has rank k, with rank 0 the highest. Arithmetic is true mod-N, with no power-of-2 assumption.
- IRR:
  - Irq passes through SYNC_STAGES flops.
  - Edge mode (LTIM=0): bit set on a synchronised 0→1 transition; cleared when acknowledged at INTA1 or when the line drops.
  - Level mode: IRR = synchronised irq each cycle.
  - IRR updates only in READY.
- int_o: registered, 1 cycle after the condition is true. Condition: exists i with IRR[i]&~IMR[i] whose rank is strictly less than the rank of the highest set ISR bit (or ISR=0). Forced 0 when not READY.
- INTA handshake, only in READY; inta outside READY is ignored:
  - Phase 0 pulse (INTA1):
    - Winner = best-rank unmasked pending bit. Set ISR[winner]; clear IRR[winner] in edge mode. Phase → 1.
    - No winner (spurious): winner = NUM_IRQ-1, and ISR is not set.
  - Phase 1 pulse (INTA2):
    - Next cycle: dout={base,winner}, dout_vld=1. Phase → 0.
    - If AEOI=1 and not spurious: clear ISR[winner]. If the AEOI-rotate flag is also set: lp=winner.
- Reads: cs&rd. Next cycle: dout_vld=1, with dout = IMR (a0=1), ISR (a0=0, RIS=1) or IRR (a0=0, RIS=0). Bits ≥ NUM_IRQ read 0.
- Simultaneous events:
  - INTA2 and rd in the same cycle: the vector wins and the read is dropped.
  - An EOI write in the same cycle as INTA1: the EOI is computed on the pre-cycle ISR, then the INTA set is applied. A set wins on the same bit.
  - An ICW1 write in the same cycle as inta: ICW1 wins and the inta is discarded.
- Reset mid-handshake: returns to UNINIT, phase 0, and no vector is issued.

Optional Feature:
- PIC_POLL_EN defined:
  - OCW3 with din[2]=1 arms poll. The next a0=0 read returns {1'b1,4'b0,winner} if an unmasked request is pending (setting ISR as INTA1 would), else 8'h00. The read then disarms poll.
  - int_o is forced 0 while poll is armed.
- PIC_POLL_EN undefined: din[2] is ignored and no poll logic is generated.

Test Plan:
- Init check:
  - Write ICW1=0x13 and ICW2=0x40 (a0=1), then ICW4=0x00 → ready=1.
  - Read a0=1 → dout=0x00.
- Edge request without AEOI:
  - Pulse irq[3] → int_o=1 within SYNC_STAGES+2 cycles.
  - inta×2 → dout=0x43, dout_vld=1, and reading ISR returns 0x08.
  - Write OCW2=0x20 → ISR=0x00 and int_o stays 0.
- Nesting:
  - With ISR[3] set, raise irq[5] → int_o stays 0.
  - Raise irq[1] → int_o=1.
  - Acknowledge → vector 0x41, ISR=0x0A.
- Rotation with NUM_IRQ=6:
  - OCW2=0xC2 sets lp=2.
  - Raise irq[1] and irq[4] together → inta vector picks level 4 (rank 1 vs rank 4).
  - Set priority with L=7 → ignored.
- AEOI plus spurious:
  - ICW4=0x02 and OCW2=0x80 (AEOI-rotate flag set); irq[2] acknowledged → ISR stays 0 and lp=2.
  - inta with nothing pending → vector {base,NUM_IRQ-1}.
- Reset mid-handshake: assert reset after INTA1 → no dout_vld, ready=0, int_o=0, IMR=0.
